// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 timing constants, receiver lock states and a tolerance helper
// for the VGA sync receiver.
package video_timing_pkg;

  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BACK      = 48;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BACK      = 33;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_HA_STA      = VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_VA_STA      = VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_TOL         = 2;
  localparam int VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } rx_state_t;

  // Measured lengths are one bit wider than the counters so a saturated
  // count plus one can never wrap back into the tolerance band.
  function automatic logic in_tol(input logic [11:0] meas, input int nom, input int tol);
    return (int'(meas) >= nom - tol) && (int'(meas) <= nom + tol);
  endfunction

endpackage

// File: rtl/video_sync_receiver_640x480_edge.sv
// Strobe-qualified falling-edge detector for an active-low sync input; the
// previous-level register only advances on pixel strobes.
module sync_edge_detect (
  input  logic clk,
  input  logic srst,
  input  logic stb,
  input  logic sync_n,
  output logic fall
);

  logic prev_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      prev_reg <= 1'b1;
    end else if (stb) begin
      prev_reg <= sync_n;
    end
  end

  assign fall = stb & prev_reg & ~sync_n;

endmodule

// File: rtl/video_sync_receiver_640x480.sv
// VGA sync receiver: recovers pixel position from HS/VS, checks line/frame
// geometry and tracks lock. Define VIDEO_RX_STATS_EN to add measurement outputs.
module video_sync_receiver_640x480
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BACK      = VGA_H_BACK,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BACK      = VGA_V_BACK,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int TOL         = VGA_TOL,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic        o_locked,
  output logic        o_active,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_frame_start,
  output logic        o_err
`ifdef VIDEO_RX_STATS_EN
  ,
  output logic [10:0] o_line_len,
  output logic [10:0] o_frame_lines,
  output logic [7:0]  o_err_cnt
`endif
);

  localparam logic [10:0] HA_STA  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HA_END  = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [10:0] VA_STA  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] VA_END  = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [10:0] H_TMO   = 11'(H_TOTAL + TOL + 1);
  localparam logic [10:0] V_TMO   = 11'(V_TOTAL + TOL + 1);
  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  rx_state_t   state_reg;
  logic [10:0] h_cnt_reg;
  logic [10:0] v_cnt_reg;
  logic [10:0] h_cnt_next;
  logic [10:0] v_cnt_next;
  logic        vs_pend_reg;
  logic [3:0]  good_cnt_reg;

  logic [1:0]  sync_n;
  logic [1:0]  sync_fall;
  logic        hs_fall;
  logic        vs_fall;
  logic        frame_evt;
  logic [11:0] line_len;
  logic [11:0] frame_lines;
  logic        line_ok;
  logic        frame_ok;
  logic        h_tmo;
  logic        v_tmo;
  logic        lock_loss;
  logic        in_win;

  // Bit 0 is HS, bit 1 is VS.
  assign sync_n = {i_vs, i_hs};

  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    sync_edge_detect u_edge (
      .clk    (i_clk),
      .srst   (i_rst),
      .stb    (i_pix_stb),
      .sync_n (sync_n[gi]),
      .fall   (sync_fall[gi])
    );
  end

  assign hs_fall = sync_fall[0];
  assign vs_fall = sync_fall[1];

  always_comb begin
    line_len    = {1'b0, h_cnt_reg} + 12'd1;
    frame_lines = {1'b0, v_cnt_reg} + 12'd1;
    // A VS edge only takes effect at the line boundary that follows it.
    frame_evt   = hs_fall & (vs_pend_reg | vs_fall);

    if (hs_fall) begin
      h_cnt_next = '0;
    end else if (h_cnt_reg == CNT_MAX) begin
      h_cnt_next = CNT_MAX;
    end else begin
      h_cnt_next = h_cnt_reg + 11'd1;
    end

    if (frame_evt) begin
      v_cnt_next = '0;
    end else if (hs_fall && (v_cnt_reg != CNT_MAX)) begin
      v_cnt_next = v_cnt_reg + 11'd1;
    end else begin
      v_cnt_next = v_cnt_reg;
    end

    line_ok   = in_tol(line_len, H_TOTAL, TOL);
    frame_ok  = in_tol(frame_lines, V_TOTAL, TOL);
    h_tmo     = i_pix_stb && !hs_fall && (h_cnt_next == H_TMO);
    v_tmo     = hs_fall && !frame_evt && (v_cnt_next == V_TMO);
    lock_loss = (state_reg == LOCKED) &&
                ((hs_fall && !line_ok) || (frame_evt && !frame_ok) || h_tmo || v_tmo);
    in_win    = (h_cnt_reg >= HA_STA) && (h_cnt_reg <= HA_END) &&
                (v_cnt_reg >= VA_STA) && (v_cnt_reg <= VA_END);
  end

  assign o_locked = (state_reg == LOCKED);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= SEARCH;
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      vs_pend_reg   <= 1'b0;
      good_cnt_reg  <= '0;
      o_active      <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
      if (i_pix_stb) begin
        h_cnt_reg <= h_cnt_next;
        v_cnt_reg <= v_cnt_next;
        if (frame_evt) begin
          vs_pend_reg <= 1'b0;
        end else if (vs_fall) begin
          vs_pend_reg <= 1'b1;
        end

        o_active <= in_win && (state_reg == LOCKED);
        o_x      <= (in_win && (state_reg == LOCKED)) ? 10'(h_cnt_reg - HA_STA) : '0;
        o_y      <= (in_win && (state_reg == LOCKED)) ? 10'(v_cnt_reg - VA_STA) : '0;

        case (state_reg)
          SEARCH: begin
            if (frame_evt) begin
              state_reg    <= TRACK;
              good_cnt_reg <= '0;
            end
          end
          TRACK: begin
            if (hs_fall && !line_ok) begin
              state_reg <= SEARCH;
            end else if (frame_evt) begin
              if (!frame_ok) begin
                state_reg <= SEARCH;
              end else begin
                good_cnt_reg <= good_cnt_reg + 4'd1;
                if (good_cnt_reg + 4'd1 >= LOCK_N) begin
                  state_reg <= LOCKED;
                end
              end
            end
          end
          LOCKED: begin
            if (lock_loss) begin
              state_reg <= SEARCH;
              o_err     <= 1'b1;
            end else if (frame_evt) begin
              o_frame_start <= 1'b1;
            end
          end
          default: state_reg <= SEARCH;
        endcase
      end
    end
  end

`ifdef VIDEO_RX_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_line_len    <= '0;
      o_frame_lines <= '0;
      o_err_cnt     <= '0;
    end else begin
      if (hs_fall) begin
        o_line_len <= line_len[11] ? CNT_MAX : line_len[10:0];
      end
      if (frame_evt) begin
        o_frame_lines <= frame_lines[11] ? CNT_MAX : frame_lines[10:0];
      end
      if (lock_loss && (o_err_cnt != 8'hFF)) begin
        o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_video_sync_receiver_640x480.sv
// Directed bench for video_sync_receiver_640x480 using a scaled-down raster
// (30 clocks x 14 lines) so several frames fit in a short run.
module tb_video_sync_receiver_640x480;

  localparam int HS   = 4;
  localparam int HB   = 4;
  localparam int HACT = 16;
  localparam int HT   = 30;
  localparam int VSY  = 2;
  localparam int VB   = 3;
  localparam int VACT = 6;
  localparam int VT   = 14;
  localparam int HA   = HS + HB;
  localparam int VA   = VSY + VB;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_stb;
  logic       hs_n;
  logic       vs_n;
  logic       locked;
  logic       active;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;
  logic       err;
`ifdef VIDEO_RX_STATS_EN
  logic [10:0] line_len;
  logic [10:0] frame_lines;
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int g_len;
  int g_nl;
  bit g_early;

  always #5 clk = ~clk;

  video_sync_receiver_640x480 #(
    .H_ACTIVE    (HACT),
    .H_SYNC      (HS),
    .H_BACK      (HB),
    .H_TOTAL     (HT),
    .V_ACTIVE    (VACT),
    .V_SYNC      (VSY),
    .V_BACK      (VB),
    .V_TOTAL     (VT),
    .TOL         (2),
    .LOCK_FRAMES (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pix_stb     (pix_stb),
    .i_hs          (hs_n),
    .i_vs          (vs_n),
    .o_locked      (locked),
    .o_active      (active),
    .o_x           (x),
    .o_y           (y),
    .o_frame_start (frame_start),
    .o_err         (err)
`ifdef VIDEO_RX_STATS_EN
    ,
    .o_line_len    (line_len),
    .o_frame_lines (frame_lines),
    .o_err_cnt     (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  function automatic logic vs_at(input int line, input int p);
    if (line < VSY) return 1'b0;
    if (g_early && (line == g_nl - 1) && (p >= g_len / 2)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick(input logic h, input logic v);
    hs_n    = h;
    vs_n    = v;
    pix_stb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_px(input int line, input int from, input int to);
    for (int p = from; p < to; p++) begin
      tick((p < HS) ? 1'b0 : 1'b1, vs_at(line, p));
    end
  endtask

  task automatic run_line(input int line);
    run_px(line, 0, g_len);
  endtask

  task automatic run_frame();
    for (int l = 0; l < g_nl; l++) run_line(l);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pix_stb = 1'b0;
    hs_n    = 1'b1;
    vs_n    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    g_len   = HT;
    g_nl    = VT;
    g_early = 1'b0;
    do_reset();

    // Reset state
    check("rst_locked", locked, 0);
    check("rst_active", active, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_fs", frame_start, 0);
    check("rst_err", err, 0);
`ifdef VIDEO_RX_STATS_EN
    check("rst_err_cnt", err_cnt, 0);
`endif

    // Nominal stream: lock on the third frame start
    run_px(0, 0, 1);
    check("f1_locked", locked, 0);
    run_px(0, 1, HT);
    for (int l = 1; l < VT; l++) run_line(l);
    run_px(0, 0, 1);
    check("f2_locked", locked, 0);
    run_px(0, 1, HT);
    for (int l = 1; l < VT; l++) run_line(l);
    run_px(0, 0, 1);
    check("f3_locked", locked, 1);
    run_px(0, 1, HT);
    for (int l = 1; l < VA; l++) run_line(l);

    // First active pixel and the pixel just before it
    run_px(VA, 0, HA + 1);
    check("pre_win_active", active, 0);
    run_px(VA, HA + 1, HA + 2);
    check("first_active", active, 1);
    check("first_x", x, 0);
    check("first_y", y, 0);
    run_px(VA, HA + 2, HT);
    for (int l = VA + 1; l < VA + VACT - 1; l++) run_line(l);

    // Last active pixel and the one after it
    run_px(VA + VACT - 1, 0, HA + HACT + 1);
    check("last_active", active, 1);
    check("last_x", x, HACT - 1);
    check("last_y", y, VACT - 1);
    run_px(VA + VACT - 1, HA + HACT + 1, HA + HACT + 2);
    check("post_win_active", active, 0);
    run_px(VA + VACT - 1, HA + HACT + 2, HT);
    for (int l = VA + VACT; l < VT; l++) run_line(l);

    // Frame start pulse while locked, one clock wide
    run_px(0, 0, 1);
    check("fs_pulse", frame_start, 1);
    run_px(0, 1, 2);
    check("fs_one_clk", frame_start, 0);
    run_px(0, 2, HT);
    for (int l = 1; l < 7; l++) run_line(l);
    run_px(7, 0, 12);
    check("mid_active", active, 1);
    check("mid_x", x, 2);
    check("mid_y", y, 2);

    // Reset mid-frame while locked
    rst     = 1'b1;
    pix_stb = 1'b1;
    hs_n    = 1'b1;
    vs_n    = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_locked", locked, 0);
    check("mrst_active", active, 0);
    check("mrst_x", x, 0);
    check("mrst_y", y, 0);
    check("mrst_fs", frame_start, 0);
    check("mrst_err", err, 0);
    rst = 1'b0;

    // Relock needs a fresh VS then two good frames
    run_px(7, 12, HT);
    for (int l = 8; l < VT; l++) run_line(l);
    check("no_vs_locked", locked, 0);
    run_frame();
    run_frame();
    check("pre_relock", locked, 0);
    run_px(0, 0, 1);
    check("relock", locked, 1);
    run_px(0, 1, HT);
    for (int l = 1; l < 6; l++) run_line(l);
    run_px(6, 0, 14);
    check("pre_frz_x", x, 4);

    // Strobe held low: everything frozen despite HS activity
    pix_stb = 1'b0;
    for (int i = 0; i < 50; i++) begin
      hs_n = ((i % 8) < 4) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    check("frz_x", x, 4);
    check("frz_y", y, 1);
    check("frz_active", active, 1);
    check("frz_locked", locked, 1);
    run_px(6, 14, 15);
    check("resume_x", x, 5);

    // Stretched geometry (+1 clock, +1 line), VS falling mid-line
    do_reset();
    g_len   = HT + 1;
    g_nl    = VT + 1;
    g_early = 1'b1;
    run_frame();
    run_frame();
    run_px(0, 0, 1);
    check("long_locked", locked, 1);
`ifdef VIDEO_RX_STATS_EN
    check("long_line_len", line_len, HT + 1);
    check("long_frame_lines", frame_lines, VT + 1);
`endif

    // HS stuck high: timeout when h_cnt reaches HT+3
    run_px(0, 1, g_len);
    run_px(1, 0, 1);
    for (int k = 1; k <= HT + 2; k++) tick(1'b1, vs_at(1, k));
    check("tmo_pre_locked", locked, 1);
    tick(1'b1, vs_at(1, HT + 3));
    check("tmo_locked", locked, 0);
    check("tmo_err", err, 1);
    check("tmo_active", active, 0);
    tick(1'b1, vs_at(1, HT + 4));
    check("tmo_err_one_clk", err, 0);
`ifdef VIDEO_RX_STATS_EN
    check("tmo_err_cnt", err_cnt, 1);
`endif

    // One short line (HT-10) while locked
    do_reset();
    g_len   = HT;
    g_nl    = VT;
    g_early = 1'b0;
`ifdef VIDEO_RX_STATS_EN
    check("rst2_err_cnt", err_cnt, 0);
`endif
    run_frame();
    run_frame();
    run_px(0, 0, 1);
    check("short_pre_locked", locked, 1);
    run_px(0, 1, HT);
    run_px(1, 0, HT - 10);
    check("short_mid_locked", locked, 1);
    run_px(2, 0, 1);
    check("short_locked", locked, 0);
    check("short_err", err, 1);
    run_px(2, 1, 2);
    check("short_err_one_clk", err, 0);
`ifdef VIDEO_RX_STATS_EN
    check("short_err_cnt", err_cnt, 1);
    check("short_line_len", line_len, HT - 10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
